// File: rtl/regfile_access_ctrl.sv
// ============================================================================
// regfile_access_ctrl
// ----------------------------------------------------------------------------
// Requester-side controller for a 3-port register file. The file has two
// registered read ports and one write port. A write on a clock edge blocks the
// read-data load on that same edge.
//
// The pipeline reaches the file through three handshakes:
//   - a writeback channel (wb_*), accepted in a single cycle with no queuing
//   - an operand-read request channel (rd_req_*, rd_rs1/rd_rs2)
//   - a read response channel (rd_resp_*, rd_data1/rd_data2)
// The controller drives the file's address, data and enable pins directly.
//
// A read goes through three states:
//   IDLE    : the read address is presented and the file loads RD1/RD2
//   CAPTURE : RD1/RD2 are valid and are copied into rd_data1/rd_data2
//   RESP    : the response is held until the consumer takes it
// Writes are accepted in every state. In IDLE a write only loses to a read.
// A read never waits behind a continuous write stream, because of the
// read_pri flag.
//
// Parameters:
//   DATA_W  register data width
//   ADDR_W  register address width (2**ADDR_W registers)
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   wb_valid/ready  writeback handshake; wb_addr, wb_data carry the payload
//   rd_req_valid/ready  read request handshake; rd_rs1, rd_rs2 are the sources
//   rd_resp_valid/ready response handshake; rd_data1, rd_data2 are the values
//   rf_A1, rf_A2    register-file read addresses
//   rf_A3, rf_WD3   register-file write address and data
//   rf_WE3          register-file write enable
//   rf_RD1, rf_RD2  register-file read data (registered inside the file)
//
// Configuration macro:
//   RF_X0_ZERO_EN   when defined, register 0 is hard-wired to zero. Writes
//                   to it are accepted but never reach the file, and reads
//                   of it return zero. When undefined, register 0 is an
//                   ordinary register.
// ============================================================================
module regfile_access_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,

    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_rs1,
    input  logic [ADDR_W-1:0] rd_rs2,

    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,

    output logic [ADDR_W-1:0] rf_A1,
    output logic [ADDR_W-1:0] rf_A2,
    output logic [ADDR_W-1:0] rf_A3,
    output logic [DATA_W-1:0] rf_WD3,
    output logic              rf_WE3,
    input  logic [DATA_W-1:0] rf_RD1,
    input  logic [DATA_W-1:0] rf_RD2
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t            state;
    logic              read_pri;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;

    logic              read_win;
    logic              wb_fire;
    logic [DATA_W-1:0] cap_data1;
    logic [DATA_W-1:0] cap_data2;

    // A read can only be issued from IDLE. It wins when no write competes,
    // or when read_pri says the write already had its turn. Reset blocks
    // all issue so that nothing reaches the file while the controller is
    // being cleared.
    assign read_win = !rst && (state == IDLE) && rd_req_valid
                      && (!wb_valid || read_pri);

    // The write channel is open whenever the cycle is not taken by a read
    // issue. In CAPTURE and RESP this means it is always open, because the
    // file holds RD on a write edge and the captured data is not disturbed.
    assign wb_ready     = !rst && !read_win;
    assign wb_fire      = wb_valid && wb_ready;
    assign rd_req_ready = read_win;

    // Register-0 suppression of the write enable. The writer still sees
    // its request accepted, so nothing upstream has to special-case it.
`ifdef RF_X0_ZERO_EN
    assign rf_WE3 = wb_fire && (wb_addr != '0);
`else
    assign rf_WE3 = wb_fire;
`endif

    // Write pins track the writeback channel all the time. Only WE3 decides
    // whether anything is stored.
    assign rf_A3  = wb_addr;
    assign rf_WD3 = wb_data;

    // Read addresses are driven straight from the request on the issue
    // cycle. At other times they hold the last issued addresses, so the
    // file's idle reloads do not toggle the address pins needlessly.
    assign rf_A1 = read_win ? rd_rs1 : rs1_q;
    assign rf_A2 = read_win ? rd_rs2 : rs2_q;

    // Values to capture out of the file in CAPTURE. With register 0
    // hard-wired, a zero source address reads as zero whatever the file
    // holds in that slot.
`ifdef RF_X0_ZERO_EN
    assign cap_data1 = (rs1_q == '0) ? '0 : rf_RD1;
    assign cap_data2 = (rs2_q == '0) ? '0 : rf_RD2;
`else
    assign cap_data1 = rf_RD1;
    assign cap_data2 = rf_RD2;
`endif

    // Main sequencer: state, arbitration priority, latched source addresses
    // and the registered response. Reset drops any in-flight read. The
    // response flag is cleared and the FSM returns to IDLE, so no response
    // is produced for a read issued before the reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            read_pri      <= 1'b0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_resp_valid <= 1'b0;
            rd_data1      <= '0;
            rd_data2      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_win) begin
                        rs1_q    <= rd_rs1;
                        rs2_q    <= rd_rs2;
                        read_pri <= 1'b0;
                        state    <= CAPTURE;
                    end else if (rd_req_valid && wb_valid) begin
                        // The write won a contested cycle, so the waiting
                        // read gets the next contested cycle.
                        read_pri <= 1'b1;
                    end
                end

                CAPTURE: begin
                    rd_data1      <= cap_data1;
                    rd_data2      <= cap_data2;
                    rd_resp_valid <= 1'b1;
                    state         <= RESP;
                end

                RESP: begin
                    if (rd_resp_ready) begin
                        rd_resp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    rd_resp_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// ============================================================================
// tb_regfile_access_ctrl
// ----------------------------------------------------------------------------
// Bench for regfile_access_ctrl. It contains a behavioural model of the
// 3-port register file with registered reads, which the controller's rf_*
// pins drive. Each read that is issued pushes its hand-computed expected
// response into a queue. An independent monitor pops the queue on every
// response handshake and compares the data.
// Handshake and pin-level expectations are checked inline by the stimulus.
// ============================================================================
module tb_regfile_access_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_rs1;
    logic [ADDR_W-1:0] rd_rs2;
    logic              rd_resp_valid;
    logic              rd_resp_ready;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [ADDR_W-1:0] rf_A1;
    logic [ADDR_W-1:0] rf_A2;
    logic [ADDR_W-1:0] rf_A3;
    logic [DATA_W-1:0] rf_WD3;
    logic              rf_WE3;
    logic [DATA_W-1:0] rf_RD1 = '0;
    logic [DATA_W-1:0] rf_RD2 = '0;

    logic [DATA_W-1:0] rfMem [0:(1<<ADDR_W)-1] = '{default: '0};

    int checks = 0;
    int errors = 0;
    logic [63:0] expQ [$];
    logic [63:0] expItem;

    // Register 0 behaviour depends on the build configuration.
`ifdef RF_X0_ZERO_EN
    localparam logic [31:0] X0_READ = 32'h0000_0000;
    localparam logic [31:0] X0_WE   = 32'd0;
`else
    localparam logic [31:0] X0_READ = 32'h0000_0055;
    localparam logic [31:0] X0_WE   = 32'd1;
`endif

    always #5 clk = ~clk;

    regfile_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_rs1        (rd_rs1),
        .rd_rs2        (rd_rs2),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .rd_data1      (rd_data1),
        .rd_data2      (rd_data2),
        .rf_A1         (rf_A1),
        .rf_A2         (rf_A2),
        .rf_A3         (rf_A3),
        .rf_WD3        (rf_WD3),
        .rf_WE3        (rf_WE3),
        .rf_RD1        (rf_RD1),
        .rf_RD2        (rf_RD2)
    );

    // Register-file model. A write edge stores and leaves RD untouched; any
    // other edge reloads RD1/RD2 from the current read addresses.
    always @(posedge clk) begin
        if (rf_WE3) begin
            rfMem[rf_A3] <= rf_WD3;
        end else begin
            rf_RD1 <= rfMem[rf_A1];
            rf_RD2 <= rfMem[rf_A2];
        end
    end

    // Comparison primitive shared by the stimulus and the monitor.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive every request-side input in one place.
    task automatic applyStimulus(input logic wbv, input logic [ADDR_W-1:0] wba,
                                 input logic [DATA_W-1:0] wbd, input logic rdv,
                                 input logic [ADDR_W-1:0] rs1,
                                 input logic [ADDR_W-1:0] rs2, input logic rr);
        wb_valid      = wbv;
        wb_addr       = wba;
        wb_data       = wbd;
        rd_req_valid  = rdv;
        rd_rs1        = rs1;
        rd_rs2        = rs2;
        rd_resp_ready = rr;
    endtask

    task automatic goIdle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
    endtask

    task automatic cycleEnd();
        @(posedge clk);
        #1;
    endtask

    // Single write with no competing read: accepted on the spot.
    task automatic writeReg(input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data,
                            input logic [31:0] expWe);
        applyStimulus(1'b1, addr, data, 1'b0, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        checkOutput("write wb_ready", 32'(wb_ready), 32'd1);
        checkOutput("write rf_WE3", 32'(rf_WE3), expWe);
        checkOutput("write rf_A3", 32'(rf_A3), 32'(addr));
        checkOutput("write rf_WD3", rf_WD3, data);
        cycleEnd();
        goIdle();
    endtask

    // CAPTURE and RESP cycles of a read with the consumer always ready.
    task automatic readTail();
        goIdle();
        @(negedge clk);
        checkOutput("resp_valid low in capture", 32'(rd_resp_valid), 32'd0);
        cycleEnd();
        @(negedge clk);
        checkOutput("resp_valid 2 cycles after accept", 32'(rd_resp_valid), 32'd1);
        cycleEnd();
    endtask

    // Uncontested read: issue, then CAPTURE and RESP.
    task automatic readReg(input logic [ADDR_W-1:0] rs1,
                           input logic [ADDR_W-1:0] rs2,
                           input logic [31:0] e1, input logic [31:0] e2);
        expQ.push_back({e1, e2});
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, rs1, rs2, 1'b1);
        @(negedge clk);
        checkOutput("read issue rd_req_ready", 32'(rd_req_ready), 32'd1);
        checkOutput("read issue rf_A1", 32'(rf_A1), 32'(rs1));
        checkOutput("read issue rf_A2", 32'(rf_A2), 32'(rs2));
        checkOutput("read issue rf_WE3", 32'(rf_WE3), 32'd0);
        cycleEnd();
        readTail();
    endtask

    // Scoreboard monitor: every response handshake consumes one expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && rd_resp_valid === 1'b1 && rd_resp_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected response: got 0x%08h/0x%08h, expected none at %0t",
                         rd_data1, rd_data2, $time);
            end else begin
                expItem = expQ.pop_front();
                checkOutput("resp rd_data1", rd_data1, expItem[63:32]);
                checkOutput("resp rd_data2", rd_data2, expItem[31:0]);
            end
        end
    end

    // Watchdog so that the run always ends with a summary.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        // ---------------- reset with all requests asserted ----------------
        rst = 1'b1;
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd1, 5'd1, 1'b1);
        cycleEnd();
        @(negedge clk);
        checkOutput("reset wb_ready", 32'(wb_ready), 32'd0);
        checkOutput("reset rd_req_ready", 32'(rd_req_ready), 32'd0);
        checkOutput("reset rf_WE3", 32'(rf_WE3), 32'd0);
        checkOutput("reset rd_resp_valid", 32'(rd_resp_valid), 32'd0);
        checkOutput("reset rd_data1", rd_data1, 32'h0);
        checkOutput("reset rd_data2", rd_data2, 32'h0);
        cycleEnd();
        rst = 1'b0;
        goIdle();
        cycleEnd();

        // ---------------- write then read ----------------
        $display("[TB] write r5 then read r5/r0");
        writeReg(5'd5, 32'hDEAD_BEEF, 32'd1);
        readReg(5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0);

        // ---------------- same-cycle conflict in IDLE ----------------
        $display("[TB] simultaneous write r3 and read r3");
        applyStimulus(1'b1, 5'd3, 32'h1234, 1'b1, 5'd3, 5'd5, 1'b1);
        @(negedge clk);
        checkOutput("conflict wb_ready", 32'(wb_ready), 32'd1);
        checkOutput("conflict rd_req_ready", 32'(rd_req_ready), 32'd0);
        checkOutput("conflict rf_WE3", 32'(rf_WE3), 32'd1);
        cycleEnd();
        expQ.push_back({32'h1234, 32'hDEAD_BEEF});
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd5, 1'b1);
        @(negedge clk);
        checkOutput("conflict read accepted next", 32'(rd_req_ready), 32'd1);
        cycleEnd();
        readTail();

        // ---------------- starvation: write offered every cycle ----------------
        $display("[TB] read against continuous writes");
        applyStimulus(1'b1, 5'd7, 32'h70, 1'b1, 5'd7, 5'd8, 1'b1);
        @(negedge clk);
        checkOutput("starve first write wins", 32'(rf_WE3), 32'd1);
        checkOutput("starve first read held", 32'(rd_req_ready), 32'd0);
        cycleEnd();
        expQ.push_back({32'h70, 32'h0});
        applyStimulus(1'b1, 5'd8, 32'h80, 1'b1, 5'd7, 5'd8, 1'b1);
        @(negedge clk);
        checkOutput("starve read wins", 32'(rd_req_ready), 32'd1);
        checkOutput("starve write held", 32'(wb_ready), 32'd0);
        checkOutput("starve no write", 32'(rf_WE3), 32'd0);
        cycleEnd();
        applyStimulus(1'b1, 5'd8, 32'h80, 1'b0, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        checkOutput("capture write accepted", 32'(rf_WE3), 32'd1);
        cycleEnd();
        applyStimulus(1'b1, 5'd9, 32'h90, 1'b0, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        checkOutput("resp write accepted", 32'(wb_ready), 32'd1);
        checkOutput("resp valid with write", 32'(rd_resp_valid), 32'd1);
        cycleEnd();
        goIdle();
        readReg(5'd8, 5'd9, 32'h80, 32'h90);

        // ---------------- write during CAPTURE not visible ----------------
        $display("[TB] write to source register during capture");
        writeReg(5'd10, 32'h11, 32'd1);
        expQ.push_back({32'h11, 32'h1234});
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd3, 1'b1);
        cycleEnd();
        applyStimulus(1'b1, 5'd10, 32'hAAAA_0000, 1'b0, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        checkOutput("capture write rf_WE3", 32'(rf_WE3), 32'd1);
        checkOutput("capture write rf_A3", 32'(rf_A3), 32'd10);
        cycleEnd();
        goIdle();
        cycleEnd();
        readReg(5'd10, 5'd3, 32'hAAAA_0000, 32'h1234);

        // ---------------- response backpressure ----------------
        $display("[TB] response backpressure");
        expQ.push_back({32'hDEAD_BEEF, 32'hAAAA_0000});
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd10, 1'b0);
        cycleEnd();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
        cycleEnd();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 5'd11, 32'hB0 + 32'(i), 1'b1, 5'd11, 5'd5, 1'b0);
            @(negedge clk);
            checkOutput("stall resp_valid", 32'(rd_resp_valid), 32'd1);
            checkOutput("stall rd_data1", rd_data1, 32'hDEAD_BEEF);
            checkOutput("stall rd_data2", rd_data2, 32'hAAAA_0000);
            checkOutput("stall rd_req_ready", 32'(rd_req_ready), 32'd0);
            checkOutput("stall write rf_WE3", 32'(rf_WE3), 32'd1);
            cycleEnd();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 5'd5, 1'b1);
        @(negedge clk);
        checkOutput("release rd_req_ready", 32'(rd_req_ready), 32'd0);
        cycleEnd();
        expQ.push_back({32'hB4, 32'hDEAD_BEEF});
        @(negedge clk);
        checkOutput("idle after release", 32'(rd_resp_valid), 32'd0);
        checkOutput("idle read accepted", 32'(rd_req_ready), 32'd1);
        cycleEnd();
        readTail();

        // ---------------- register 0 ----------------
        $display("[TB] register 0 write and read");
        writeReg(5'd0, 32'h55, X0_WE);
        readReg(5'd0, 5'd5, X0_READ, 32'hDEAD_BEEF);

        // ---------------- reset with a read in CAPTURE ----------------
        $display("[TB] reset during capture");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 1'b1);
        cycleEnd();
        rst = 1'b1;
        applyStimulus(1'b1, 5'd12, 32'hCC, 1'b1, 5'd5, 5'd5, 1'b1);
        @(negedge clk);
        checkOutput("midreset wb_ready", 32'(wb_ready), 32'd0);
        checkOutput("midreset rf_WE3", 32'(rf_WE3), 32'd0);
        checkOutput("midreset rd_req_ready", 32'(rd_req_ready), 32'd0);
        cycleEnd();
        rst = 1'b0;
        goIdle();
        @(negedge clk);
        checkOutput("after reset rd_data1", rd_data1, 32'h0);
        checkOutput("after reset rd_data2", rd_data2, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("dropped read no response", 32'(rd_resp_valid), 32'd0);
            cycleEnd();
        end
        readReg(5'd12, 5'd5, 32'h0, 32'hDEAD_BEEF);

        goIdle();
        repeat (3) cycleEnd();
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Requester-side controller for the 3-port register file (two registered read ports, one write port). A single write blocks reads in that cycle.
- Accepts writeback requests and operand-read requests from the pipeline over valid/ready handshakes, and drives the register-file address/data/enable pins.
- Captures the registered read data and returns it on a response handshake.
- Arbitrates reads against writes without starving either side.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (2**ADDR_W registers)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- wb_valid  in  1  writeback request valid
- wb_ready  out  1  writeback accepted this cycle
- wb_addr  in  ADDR_W  destination register
- wb_data  in  DATA_W  write data
- rd_req_valid  in  1  operand-read request valid
- rd_req_ready  out  1  read request accepted this cycle
- rd_rs1  in  ADDR_W  first source register
- rd_rs2  in  ADDR_W  second source register
- rd_resp_valid  out  1  response data valid
- rd_resp_ready  in  1  consumer accepts response
- rd_data1  out  DATA_W  value of rs1
- rd_data2  out  DATA_W  value of rs2
- rf_A1  out  ADDR_W  register-file read address 1
- rf_A2  out  ADDR_W  register-file read address 2
- rf_A3  out  ADDR_W  register-file write address
- rf_WD3  out  DATA_W  register-file write data
- rf_WE3  out  1  register-file write enable
- rf_RD1  in  DATA_W  register-file read data 1 (registered inside file)
- rf_RD2  in  DATA_W  register-file read data 2 (registered inside file)

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous and active-high.
- Register-file contract: on an edge with WE3=1 the file writes and RD holds. On an edge with WE3=0 the file loads RD1/RD2 from A1/A2. RD is therefore valid the cycle after a non-write issue cycle.
- States:
  - IDLE: may issue a read or a write.
  - CAPTURE: rf_RD valid.
  - RESP: response held.
- Reset values: state=IDLE, rd_resp_valid=0, rd_data1/2=0, read_pri=0. While rst=1: rf_WE3=0, wb_ready=0, rd_req_ready=0.
- Reset mid-operation: any in-flight read is dropped with no response; no write is issued in the reset cycle.
- Port pins are combinational from state and request inputs.
  - When not issuing: rf_A1/A2 hold the last issued read addresses (registered copies).
  - When no write is issued: rf_A3/rf_WD3 follow wb_addr/wb_data with rf_WE3=0.
- Write acceptance: wb_ready=1 in CAPTURE and RESP whenever not in reset. In IDLE, wb_ready=1 unless a read wins arbitration.
  - On acceptance: rf_WE3=1, rf_A3=wb_addr, rf_WD3=wb_data in the same cycle. Single-cycle, no queuing.
- IDLE arbitration:
  - Both valid and read_pri=0: the write wins, and read_pri is set to 1.
  - Both valid and read_pri=1: the read wins, and read_pri is cleared.
  - Only one valid: it is served.
  - read_pri is also cleared whenever a read is accepted.
- Read issue (IDLE, read wins): rd_req_ready=1, rf_A1=rd_rs1, rf_A2=rd_rs2, rf_WE3=0, and rs1/rs2 are registered. Next state is CAPTURE.
- CAPTURE: rd_data1/2 <= rf_RD1/RD2 (subject to x0 rule). rd_resp_valid <= 1. Next state is RESP. A write in this cycle is legal because RD holds during a write.
- RESP: rd_resp_valid=1, and rd_data1/2 stay stable until rd_resp_ready=1.
  - On the handshake edge: rd_resp_valid <= 0, next state is IDLE.
  - rd_req_ready=0 in this state.
- Latency and throughput:
  - Response visible 2 cycles after read acceptance; best-case read throughput is 1 per 3 cycles.
  - Write throughput is 1 per cycle, except in an IDLE cycle lost to a read.
- Ordering: a read observes every write accepted strictly before it, and no write accepted after it, including writes in CAPTURE/RESP.
- Same-cycle IDLE conflict: write first, then read, so the read sees the write.

Optional Feature:
- Macro: RF_X0_ZERO_EN.
- Defined:
  - A write with wb_addr=0 is accepted (wb_ready=1) but rf_WE3 stays 0.
  - In CAPTURE, rd_dataN is forced to 0 when the registered rsN=0.
- Undefined: register 0 is an ordinary register; writes and reads pass through unchanged.

Test Plan:
- Reset: assert rst with a read in CAPTURE -> after reset, state IDLE, rd_resp_valid=0, rd_data1/2=0, rf_WE3=0, and no response ever appears.
- Write then read: write r5=0xDEADBEEF, then read rs1=5, rs2=0 (macro on) -> rd_resp_valid 2 cycles after acceptance, rd_data1=0xDEADBEEF, rd_data2=0.
- Simultaneous requests in IDLE (write r3=0x1234, read rs1=3):
  - Write accepted first, with wb_ready=1 and rd_req_ready=0.
  - Read accepted the next cycle and returns rd_data1=0x1234.
- Starvation: wb_valid held high every cycle plus a pending read -> read accepted within 2 IDLE cycles (read_pri).
- Write during CAPTURE/RESP to the issued rs1 with 0xAAAA0000 (old value 0x11) -> response rd_data1=0x11; a following read returns 0xAAAA0000.
- Backpressure: rd_resp_ready=0 for 5 cycles -> rd_resp_valid=1 with data stable, rd_req_ready=0, writes still accepted; release -> back to IDLE next cycle.
